// File: rtl/apb_slave_mem.sv
// APB slave backed by a small register memory with a read-only window and WAIT_CYCLES wait states.
// PREADY asserts WAIT_CYCLES+1 enable cycles after setup; PSEL dropped mid-access aborts the transfer.
module apb_slave_mem #(
   parameter int ADDR_WIDTH  = 7,
   parameter int DATA_WIDTH  = 8,
   parameter int MEM_DEPTH   = 48,
   parameter int RO_BASE     = 40,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PREADY,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PSLVERR,
   output logic [1:0]            slave_state
);

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_ACCESS = 2'b01;
   localparam logic [1:0] ST_DONE   = 2'b10;

   localparam int         IDX_W   = 6;
   localparam logic [6:0] DEPTH7  = 7'(MEM_DEPTH);
   localparam logic [6:0] RO7     = 7'(RO_BASE);
   localparam logic [3:0] WAIT4   = 4'(WAIT_CYCLES);

   logic [1:0]            state;
   logic [3:0]            cnt;
   logic [IDX_W-1:0]      lat_addr;
   logic                  lat_write;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [IDX_W-1:0]      live_addr;
   logic [DATA_WIDTH-1:0] live_word;
   logic [DATA_WIDTH-1:0] live_rdata;
   logic                  live_err;
   logic [DATA_WIDTH-1:0] lat_word;
   logic [DATA_WIDTH-1:0] lat_rdata;
   logic                  lat_err;
   logic                  setup_seen;

   // PADDR[6] is the master's select decode and carries no meaning here
   logic unused_paddr;
   assign unused_paddr = ^PADDR[ADDR_WIDTH-1:IDX_W];

   function automatic logic is_unmapped(input logic [IDX_W-1:0] a);
      return ({1'b0, a} >= DEPTH7);
   endfunction

   function automatic logic is_error(input logic [IDX_W-1:0] a, input logic wr);
      return is_unmapped(a) || (wr && ({1'b0, a} >= RO7));
   endfunction

   assign live_addr   = PADDR[IDX_W-1:0];
   assign setup_seen  = PSEL && !PENABLE;
   assign slave_state = state;

   // Response for both the live setup address (zero-wait case) and the latched one
   always_comb begin
      live_word = '0;
      lat_word  = '0;
      if (!is_unmapped(live_addr)) begin
         live_word = mem[live_addr];
      end
      if (!is_unmapped(lat_addr)) begin
         lat_word = mem[lat_addr];
      end
      live_err   = is_error(live_addr, PWRITE);
      lat_err    = is_error(lat_addr, lat_write);
      live_rdata = (PWRITE || is_unmapped(live_addr)) ? '0 : live_word;
      lat_rdata  = (lat_write || is_unmapped(lat_addr)) ? '0 : lat_word;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_write <= 1'b0;
         lat_wdata <= '0;
         PREADY    <= 1'b0;
         PRDATA    <= '0;
         PSLVERR   <= 1'b0;
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               PREADY  <= 1'b0;
               PRDATA  <= '0;
               PSLVERR <= 1'b0;
               if (setup_seen) begin
                  state     <= ST_ACCESS;
                  lat_addr  <= live_addr;
                  lat_write <= PWRITE;
                  lat_wdata <= PWDATA;
                  cnt       <= WAIT4;
                  if (WAIT4 == 4'd0) begin
                     PREADY  <= 1'b1;
                     PRDATA  <= live_rdata;
                     PSLVERR <= live_err;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (!PSEL) begin
                  state   <= ST_IDLE;
                  PREADY  <= 1'b0;
                  PRDATA  <= '0;
                  PSLVERR <= 1'b0;
               end else if (PENABLE) begin
                  if (PREADY) begin
                     if (lat_write && !lat_err) begin
                        mem[lat_addr] <= lat_wdata;
                     end
                     state   <= ST_DONE;
                     PREADY  <= 1'b0;
                     PRDATA  <= '0;
                     PSLVERR <= 1'b0;
                  end else if (cnt > 4'd1) begin
                     cnt <= cnt - 4'd1;
                  end else if (cnt == 4'd1) begin
                     cnt     <= 4'd0;
                     PREADY  <= 1'b1;
                     PRDATA  <= lat_rdata;
                     PSLVERR <= lat_err;
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               PREADY  <= 1'b0;
               PRDATA  <= '0;
               PSLVERR <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances (0, 3 and 2 wait states) checked each cycle
// against a transaction-level model that predicts outputs from the transfer being driven.
module tb_apb_slave_mem;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic [2:0] psel;
   logic       PENABLE;
   logic       PWRITE;
   logic [6:0] PADDR;
   logic [7:0] PWDATA;

   logic [2:0] pready;
   logic [2:0] pslverr;
   logic [7:0] prdata [3];
   logic [1:0] sstate [3];

   always #5 PCLK = ~PCLK;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
      apb_slave_mem #(.WAIT_CYCLES(W)) u_dut (
         .PCLK        (PCLK),
         .PRESET      (PRESET),
         .PSEL        (psel[g]),
         .PENABLE     (PENABLE),
         .PWRITE      (PWRITE),
         .PADDR       (PADDR),
         .PWDATA      (PWDATA),
         .PREADY      (pready[g]),
         .PRDATA      (prdata[g]),
         .PSLVERR     (pslverr[g]),
         .slave_state (sstate[g])
      );
   end

   int         checks = 0;
   int         errors = 0;
   int         cur    = 0;
   bit         chk_en = 0;
   bit         exp_rdy;
   bit         exp_err;
   logic [7:0] exp_dat;
   logic [1:0] exp_st;
   logic [7:0] cap_dat;
   logic       cap_err;
   logic [7:0] mem_m [3][64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, cur, act, req, $time);
      end
   endtask

   function automatic int wait_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
   endfunction

   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_quiet(input logic [1:0] st);
      exp_st  = st;
      exp_rdy = 1'b0;
      exp_err = 1'b0;
      exp_dat = 8'h00;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 64; j++)
            mem_m[i][j] = 8'h00;
   endtask

   task automatic idle(input int n);
      psel    = '0;
      PENABLE = 1'b0;
      for (int k = 0; k < n; k++) begin
         cyc();
         set_quiet(2'b00);
      end
   endtask

   // One full transfer on instance cur; leaves the bench inside the DONE cycle
   task automatic xfer(input bit wr, input logic [6:0] addr, input logic [7:0] data);
      int         w;
      logic [5:0] a;
      bit         err;
      logic [7:0] rd;
      w   = wait_of(cur);
      a   = addr[5:0];
      err = (a >= 6'd48) || (wr && a >= 6'd40);
      rd  = (!wr && a < 6'd48) ? mem_m[cur][a] : 8'h00;
      psel      = '0;
      psel[cur] = 1'b1;
      PENABLE   = 1'b0;
      PWRITE    = wr;
      PADDR     = addr;
      PWDATA    = data;
      cyc();
      PENABLE = 1'b1;
      PADDR   = addr ^ 7'h15;
      PWDATA  = ~data;
      for (int k = 1; k <= w + 1; k++) begin
         exp_st  = 2'b01;
         exp_rdy = (k == w + 1);
         exp_err = exp_rdy && err;
         exp_dat = exp_rdy ? rd : 8'h00;
         cyc();
      end
      if (wr && !err) mem_m[cur][a] = data;
      set_quiet(2'b10);
      psel    = '0;
      PENABLE = 1'b0;
   endtask

   always @(negedge PCLK) begin
      if (chk_en) begin
         chk("pready",  32'(pready[cur]),  32'(exp_rdy));
         chk("pslverr", 32'(pslverr[cur]), 32'(exp_err));
         chk("prdata",  32'(prdata[cur]),  32'(exp_dat));
         chk("state",   32'(sstate[cur]),  32'(exp_st));
         if (exp_rdy) begin
            cap_dat = prdata[cur];
            cap_err = pslverr[cur];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      PRESET  = 1'b1;
      psel    = '0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = '0;
      PWDATA  = '0;
      cap_dat = 8'hFF;
      cap_err = 1'b1;
      clear_model();
      cyc();
      set_quiet(2'b00);
      chk_en = 1'b1;
      cyc();
      PRESET = 1'b0;
      idle(2);

      // zero wait states
      cur = 0;
      xfer(1'b1, 7'h03, 8'hA5);
      chk("lit_wr03_err", 32'(cap_err), 32'h0);
      idle(1);
      xfer(1'b0, 7'h03, 8'h00);
      chk("lit_rd03", 32'(cap_dat), 32'hA5);
      idle(1);

      // PENABLE high without a setup phase must be ignored
      psel[0] = 1'b1;
      PENABLE = 1'b1;
      PWRITE  = 1'b1;
      PADDR   = 7'h03;
      PWDATA  = 8'hEE;
      cyc();
      set_quiet(2'b00);
      idle(1);
      xfer(1'b0, 7'h03, 8'h00);
      chk("lit_viol_rd03", 32'(cap_dat), 32'hA5);
      idle(1);

      // error windows
      xfer(1'b1, 7'h28, 8'h77);
      chk("lit_ro_wr_err", 32'(cap_err), 32'h1);
      idle(1);
      xfer(1'b0, 7'h28, 8'h00);
      chk("lit_ro_rd_dat", 32'(cap_dat), 32'h00);
      chk("lit_ro_rd_err", 32'(cap_err), 32'h0);
      idle(1);
      xfer(1'b0, 7'h30, 8'h00);
      chk("lit_unm_rd_err", 32'(cap_err), 32'h1);
      chk("lit_unm_rd_dat", 32'(cap_dat), 32'h00);
      idle(1);
      xfer(1'b1, 7'h3F, 8'h12);
      chk("lit_unm_wr_err", 32'(cap_err), 32'h1);
      idle(1);
      xfer(1'b1, 7'h27, 8'h5C);
      chk("lit_rw_top_err", 32'(cap_err), 32'h0);

      // back-to-back, setup in the DONE cycle
      xfer(1'b1, 7'h01, 8'h11);
      xfer(1'b0, 7'h01, 8'h00);
      chk("lit_b2b_rd01", 32'(cap_dat), 32'h11);
      xfer(1'b0, 7'h27, 8'h00);
      chk("lit_b2b_rd27", 32'(cap_dat), 32'h5C);
      idle(1);

      // PADDR[6] ignored
      xfer(1'b1, 7'h45, 8'hC3);
      idle(1);
      xfer(1'b0, 7'h05, 8'h00);
      chk("lit_alias_rd05", 32'(cap_dat), 32'hC3);
      idle(1);

      // three wait states
      cur = 1;
      idle(1);
      xfer(1'b1, 7'h10, 8'h3C);
      idle(1);
      xfer(1'b0, 7'h10, 8'h00);
      chk("lit_w3_rd10", 32'(cap_dat), 32'h3C);
      xfer(1'b1, 7'h2A, 8'h01);
      chk("lit_w3_ro_err", 32'(cap_err), 32'h1);
      idle(1);

      // abort in E1 with two wait states
      cur = 2;
      idle(1);
      psel[2] = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 7'h02;
      PWDATA  = 8'h99;
      cyc();
      set_quiet(2'b01);
      psel[2] = 1'b0;
      PENABLE = 1'b1;
      cyc();
      set_quiet(2'b00);
      PENABLE = 1'b0;
      idle(1);
      xfer(1'b0, 7'h02, 8'h00);
      chk("lit_abort_rd02", 32'(cap_dat), 32'h00);
      xfer(1'b1, 7'h02, 8'h4B);
      xfer(1'b0, 7'h02, 8'h00);
      chk("lit_w2_rd02", 32'(cap_dat), 32'h4B);
      idle(1);

      // reset mid-transfer: the pending write must not land and memory clears
      cur = 0;
      idle(1);
      xfer(1'b1, 7'h05, 8'h5A);
      idle(1);
      psel[0] = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 7'h06;
      PWDATA  = 8'h66;
      cyc();
      exp_st  = 2'b01;
      exp_rdy = 1'b1;
      exp_err = 1'b0;
      exp_dat = 8'h00;
      PENABLE = 1'b1;
      PRESET  = 1'b1;
      cyc();
      set_quiet(2'b00);
      clear_model();
      cyc();
      PRESET  = 1'b0;
      psel    = '0;
      PENABLE = 1'b0;
      idle(1);
      xfer(1'b0, 7'h05, 8'h00);
      chk("lit_rst_rd05", 32'(cap_dat), 32'h00);
      xfer(1'b0, 7'h06, 8'h00);
      chk("lit_rst_rd06", 32'(cap_dat), 32'h00);
      idle(1);
      cur = 1;
      idle(1);
      xfer(1'b0, 7'h10, 8'h00);
      chk("lit_rst_w3_rd10", 32'(cap_dat), 32'h00);
      idle(2);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
